spi_slave_control: RTL and testbench

- SPI responder for the opposite end of the link driven by the team's SPI master controller.
- Oversamples the master's SPI_CLK, SPI_MO and a frame select SPI_CS_N on the local clk.
- Shifts received bits MSB-first into a word and returns a preloaded word on SPI_MI.
- Flags frame completion to local logic.
- Mode: the master changes SPI_MO after falling SPI_CLK and samples SPI_MI on rising SPI_CLK. The slave mirrors this: it samples on rising and drives on falling.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_slave_control_if.sv | 27 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_control.sv | 157 +++++++++++++++
 tb/tb_spi_slave_control.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM state encoding and widths.
package spi_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BITS_W     = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/spi_slave_control_if.sv
// SPI pad signals plus the local word/status bus of the SPI responder.
interface spi_slave_control_if #(
  parameter int DATA_W = 32
) ();

  logic                       SPI_CLK;
  logic                       SPI_CS_N;
  logic                       SPI_MO;
  logic                       SPI_MI;
  logic [DATA_W-1:0]          slv_odata;
  logic [DATA_W-1:0]          slv_idata;
  logic [spi_pkg::BITS_W-1:0] slv_bits;
  logic                       slv_busy;
  logic                       slv_done;
  logic                       slv_ovf;

  modport slave (
    input  SPI_CLK, SPI_CS_N, SPI_MO, slv_odata,
    output SPI_MI, slv_idata, slv_bits, slv_busy, slv_done, slv_ovf
  );

  modport master (
    output SPI_CLK, SPI_CS_N, SPI_MO, slv_odata,
    input  SPI_MI, slv_idata, slv_bits, slv_busy, slv_done, slv_ovf
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI input, with one extra
// history flop so rising/falling edges of the synchronised level are visible.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pad level through the synchroniser and remember the last synchronised level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_control.sv
// SPI responder: samples SPI_MO on rising SPI_CLK into a right-aligned word,
// returns a word snapshotted at frame start on SPI_MI (changed on falling
// SPI_CLK), and reports frame completion with a one-cycle pulse.
module spi_slave_control
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = DATA_W_DEF
) (
  input logic               clk,
  input logic               rst,
  spi_slave_control_if.slave bus
);

  logic clk_sync_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_act;
  logic cs_rise_unused;
  logic cs_fall_unused;
  logic mo_sync;
  logic mo_rise_unused;
  logic mo_fall_unused;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   idata_q, idata_d;
  logic [BITS_W-1:0]   bits_q, bits_d;
  logic                mi_q, mi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.SPI_CLK),
    .sync_o (clk_sync_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // The select is inverted before synchronising so reset-to-zero flops mean "no frame"
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (~bus.SPI_CS_N),
    .sync_o (cs_act),
    .rise_o (cs_rise_unused),
    .fall_o (cs_fall_unused)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mo (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.SPI_MO),
    .sync_o (mo_sync),
    .rise_o (mo_rise_unused),
    .fall_o (mo_fall_unused)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= {DATA_W{1'b0}};
      idata_q <= {DATA_W{1'b0}};
      bits_q  <= {BITS_W{1'b0}};
      mi_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      idata_q <= idata_d;
      bits_q  <= bits_d;
      mi_q    <= mi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Frame sequencing: start on select, shift on SCLK edges, close when select drops
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    idata_d = idata_q;
    bits_d  = bits_q;
    mi_d    = mi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        mi_d   = 1'b0;
        busy_d = 1'b0;
        if (cs_act) begin
          state_d = ACTIVE;
          tx_d    = bus.slv_odata;
          mi_d    = bus.slv_odata[DATA_W-1];
          idata_d = {DATA_W{1'b0}};
          bits_d  = {BITS_W{1'b0}};
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (!cs_act) begin
          // Deselect wins over any SCLK edge seen in the same cycle
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          mi_d    = 1'b0;
        end else if (sclk_rise) begin
          if (bits_q < BITS_W'(DATA_W)) begin
            idata_d = {idata_q[DATA_W-2:0], mo_sync};
            bits_d  = bits_q + BITS_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bits_q == {BITS_W{1'b0}}) begin
            // A fall before any sampled bit carries no data
            mi_d = 1'b0;
          end else begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
            mi_d = tx_q[DATA_W-2];
          end
        end else begin
          state_d = ACTIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        mi_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        mi_d    = 1'b0;
      end
    endcase
  end

  assign bus.SPI_MI    = mi_q;
  assign bus.slv_idata = idata_q;
  assign bus.slv_bits  = bits_q;
  assign bus.slv_busy  = busy_q;
  assign bus.slv_done  = done_q;
  assign bus.slv_ovf   = ovf_q;

endmodule

// File: tb/tb_spi_slave_control.sv
// Bench for spi_slave_control: directed frames plus randomized frames against
// a reference model of the responder's frame rules.
module tb_spi_slave_control;

  localparam int S  = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  logic [63:0] mi_word;

  // reference model state
  bit          m_busy, m_done, m_cool, m_mi, m_ovf;
  bit          rxq[$];
  int          m_shifts;
  logic [DW-1:0] m_tx;
  bit          hc[0:S];
  bit          hs[0:S];
  bit          hm[0:S];

  spi_slave_control_if #(.DATA_W(DW)) bus ();

  spi_slave_control #(.SYNC_STAGES(S), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_idata();
    logic [DW-1:0] v;
    v = {DW{1'b0}};
    foreach (rxq[i]) v = {v[DW-2:0], rxq[i]};
    return v;
  endfunction

  // one clk edge of the reference: pad levels are seen S cycles late
  task automatic model_step();
    bit c_cur, c_prv, cs_cur, mo_cur;
    if (rst) begin
      m_busy = 0; m_done = 0; m_cool = 0; m_mi = 0; m_ovf = 0;
      rxq.delete(); m_shifts = 0; m_tx = {DW{1'b0}};
      for (int i = 0; i <= S; i++) begin hc[i] = 0; hs[i] = 0; hm[i] = 0; end
    end else begin
      c_cur = hc[S-1]; c_prv = hc[S]; cs_cur = hs[S-1]; mo_cur = hm[S-1];
      m_done = 0;
      if (m_busy) begin
        if (!cs_cur) begin
          m_busy = 0; m_done = 1; m_mi = 0; m_cool = 1;
        end else if (c_cur && !c_prv) begin
          if (rxq.size() < DW) rxq.push_back(mo_cur);
          else m_ovf = 1;
        end else if (!c_cur && c_prv) begin
          if (rxq.size() == 0) m_mi = 0;
          else begin
            m_shifts++;
            m_mi = (m_shifts < DW) ? m_tx[DW-1-m_shifts] : 1'b0;
          end
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (cs_cur) begin
        m_busy = 1; m_tx = bus.slv_odata; m_mi = m_tx[DW-1];
        rxq.delete(); m_shifts = 0; m_ovf = 0;
      end
      for (int i = S; i > 0; i--) begin hc[i] = hc[i-1]; hs[i] = hs[i-1]; hm[i] = hm[i-1]; end
      hc[0] = bus.SPI_CLK; hs[0] = !bus.SPI_CS_N; hm[0] = bus.SPI_MO;
    end
  endtask

  // every cycle: advance the model and compare all outputs
  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      check("busy",  bus.slv_busy,  m_busy);
      check("done",  bus.slv_done,  m_done);
      check("mi",    bus.SPI_MI,    m_mi);
      check("bits",  bus.slv_bits,  rxq.size());
      check("idata", bus.slv_idata, model_idata());
      check("ovf",   bus.slv_ovf,   m_ovf);
      if (bus.slv_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low(input int h);
    bus.SPI_CS_N = 1'b0;
    cyc(h);
  endtask

  task automatic cs_high(input int h);
    cyc(h);
    bus.SPI_CS_N = 1'b1;
    cyc(h);
  endtask

  // send the low n bits of v, MSB first; record SPI_MI just before each rise
  task automatic send_bits(input logic [63:0] v, input int n, input int h);
    for (int i = n - 1; i >= 0; i--) begin
      bus.SPI_MO = v[i];
      cyc(h);
      mi_word = {mi_word[62:0], bus.SPI_MI};
      bus.SPI_CLK = 1'b1;
      cyc(h);
      bus.SPI_CLK = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] d;
    int n, h;
    rst = 1'b1;
    bus.SPI_CLK = 1'b0; bus.SPI_CS_N = 1'b1; bus.SPI_MO = 1'b0;
    bus.slv_odata = 32'h0;
    mi_word = 64'h0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check("rst_busy",  bus.slv_busy,  32'h0);
    check("rst_bits",  bus.slv_bits,  32'h0);
    check("rst_idata", bus.slv_idata, 32'h0);
    check("rst_mi",    bus.SPI_MI,    32'h0);
    check("rst_done",  done_cnt,      32'h0);

    // full 32-bit frame; odata changed after start must not matter
    bus.slv_odata = 32'hA5C3_0F96;
    done_cnt = 0; mi_word = 64'h0;
    cs_low(6);
    bus.slv_odata = 32'hFFFF_0000;
    send_bits(64'h1234_5678, 32, 6);
    cs_high(6);
    check("full_idata",  bus.slv_idata,  32'h1234_5678);
    check("full_bits",   bus.slv_bits,   32'd32);
    check("full_ovf",    bus.slv_ovf,    32'h0);
    check("full_miword", mi_word[31:0],  32'hA5C3_0F96);
    check("full_done",   done_cnt,       32'd1);
    check("model_idata", model_idata(),  32'h1234_5678);

    // short 8-bit frame
    done_cnt = 0;
    cs_low(5);
    send_bits(64'hC5, 8, 5);
    cs_high(5);
    check("short_idata", bus.slv_idata, 32'h0000_00C5);
    check("short_bits",  bus.slv_bits,  32'd8);
    check("short_done",  done_cnt,      32'd1);

    // 34 rising edges: saturate at 32, overflow after the 33rd
    cs_low(5);
    send_bits(64'hDEAD_BEEF, 32, 5);
    check("ovf_pre", bus.slv_ovf, 32'h0);
    send_bits(64'h1, 1, 5);
    check("ovf_33", bus.slv_ovf, 32'h1);
    send_bits(64'h1, 1, 5);
    cs_high(5);
    check("ovf_idata", bus.slv_idata, 32'hDEAD_BEEF);
    check("ovf_bits",  bus.slv_bits,  32'd32);
    check("ovf_flag",  bus.slv_ovf,   32'h1);

    // reset after bit 10: silent abort, then a clean 4-bit frame
    done_cnt = 0;
    cs_low(5);
    send_bits(64'h2AA, 10, 5);
    rst = 1'b1; bus.SPI_CS_N = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("abort_busy",  bus.slv_busy,  32'h0);
    check("abort_bits",  bus.slv_bits,  32'h0);
    check("abort_idata", bus.slv_idata, 32'h0);
    cyc(8);
    check("abort_nodone", done_cnt, 32'h0);
    cs_low(5);
    send_bits(64'h9, 4, 5);
    cs_high(5);
    check("after_idata", bus.slv_idata, 32'h9);
    check("after_bits",  bus.slv_bits,  32'd4);

    // deselect coincident with an SCLK rise: the rise is dropped
    done_cnt = 0;
    cs_low(5);
    send_bits(64'hB, 4, 5);
    bus.SPI_MO = 1'b0;
    cyc(5);
    bus.SPI_CLK = 1'b1; bus.SPI_CS_N = 1'b1;
    cyc(5);
    bus.SPI_CLK = 1'b0;
    cyc(8);
    check("coin_bits",  bus.slv_bits,  32'd4);
    check("coin_idata", bus.slv_idata, 32'hB);
    check("coin_done",  done_cnt,      32'd1);

    // empty frame
    done_cnt = 0;
    cs_low(5);
    cs_high(5);
    check("empty_bits",  bus.slv_bits,  32'h0);
    check("empty_idata", bus.slv_idata, 32'h0);
    check("empty_done",  done_cnt,      32'd1);

    // randomized frames with mid-frame odata changes and short gaps
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(0, 34);
      h = $urandom_range(S + 2, 8);
      d = {$urandom, $urandom};
      bus.slv_odata = $urandom;
      cs_low(h);
      for (int i = n - 1; i >= 0; i--) begin
        send_bits(d >> i, 1, h);
        if ($urandom_range(0, 3) == 0) bus.slv_odata = $urandom;
      end
      cyc(h);
      bus.SPI_CS_N = 1'b1;
      cyc($urandom_range(1, 6));
    end
    cyc(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
